router_reg: RTL and testbench



---
 rtl/router_pkg.sv | 23 ++
 rtl/router_reg_if.sv | 31 +++
 rtl/router_parity_acc.sv | 41 ++++
 rtl/router_reg.sv | 100 ++++++++++
 tb/tb_router_reg.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared widths, header field positions and port addresses for the router datapath.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  localparam logic [1:0] ADDR_P0 = 2'b00;
  localparam logic [1:0] ADDR_P1 = 2'b01;
  localparam logic [1:0] ADDR_P2 = 2'b10;

  // Where the dout register takes its next value from
  typedef enum logic [2:0] {
    DSEL_HOLD,
    DSEL_HDR,
    DSEL_DIN,
    DSEL_STASH,
    DSEL_FBYTE
  } dout_sel_e;

endpackage

// File: rtl/router_reg_if.sv
// Input-port / FSM-strobe / FIFO-write bundle seen by the router register stage.
interface router_reg_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [DATA_W-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity, captured packet parity and the mismatch flag.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              err_clear,
  input  logic              xor_en,
  input  logic [DATA_W-1:0] xor_data,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              check_en,
  output logic              err
);

  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else begin
      if (clear)
        int_parity <= '0;
      else if (xor_en)
        int_parity <= int_parity ^ xor_data;

      if (cap_en)
        pkt_parity <= cap_data;

      if (err_clear)
        err <= 1'b0;
      else if (check_en)
        err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router register stage: header capture, dout retiming, full-byte stash and parity flags.
module router_reg
  import router_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  router_reg_if.slave bus
);

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] full_byte_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              parity_done_reg;
  logic              low_pkt_valid_reg;
  logic              err_w;

  dout_sel_e         dsel;
  logic              xor_en;
  logic [DATA_W-1:0] xor_data;
  logic              pd_set;

  always_comb begin
    dsel = DSEL_HOLD;
    if (bus.lfd_state)
      dsel = DSEL_HDR;
    else if (bus.ld_state && !bus.fifo_full)
      dsel = DSEL_DIN;
    else if (bus.ld_state)
      dsel = DSEL_STASH;
    else if (bus.laf_state)
      dsel = DSEL_FBYTE;
  end

  // The parity byte (pkt_valid low) and bytes replayed after a full stall are never folded
  always_comb begin
    xor_en   = 1'b0;
    xor_data = bus.data_in;
    if (bus.lfd_state) begin
      xor_en   = 1'b1;
      xor_data = header_reg;
    end else if (bus.ld_state && bus.pkt_valid && !bus.full_state) begin
      xor_en = 1'b1;
    end
  end

  always_comb begin
    pd_set = (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
             (bus.laf_state && low_pkt_valid_reg && !parity_done_reg);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      header_reg        <= '0;
      full_byte_reg     <= '0;
      dout_reg          <= '0;
      parity_done_reg   <= 1'b0;
      low_pkt_valid_reg <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid)
        header_reg <= bus.data_in;

      unique case (dsel)
        DSEL_HDR:   dout_reg      <= header_reg;
        DSEL_DIN:   dout_reg      <= bus.data_in;
        DSEL_STASH: full_byte_reg <= bus.data_in;
        DSEL_FBYTE: dout_reg      <= full_byte_reg;
        default:    ;
      endcase

      if (bus.detect_add)
        parity_done_reg <= 1'b0;
      else if (pd_set)
        parity_done_reg <= 1'b1;

      if (bus.ld_state && !bus.pkt_valid)
        low_pkt_valid_reg <= 1'b1;
      else if (bus.rst_int_reg)
        low_pkt_valid_reg <= 1'b0;
    end
  end

  router_parity_acc u_parity (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (bus.detect_add),
    .err_clear (bus.detect_add && bus.pkt_valid),
    .xor_en    (xor_en),
    .xor_data  (xor_data),
    .cap_en    (bus.ld_state && !bus.pkt_valid),
    .cap_data  (bus.data_in),
    .check_en  (bus.rst_int_reg && parity_done_reg),
    .err       (err_w)
  );

  assign bus.dout          = dout_reg;
  assign bus.parity_done   = parity_done_reg;
  assign bus.low_pkt_valid = low_pkt_valid_reg;
  assign bus.err           = err_w;

endmodule

// File: tb/tb_router_reg.sv
// Packet-level driver plays the router FSM; a queue-fed monitor checks every registered output.
module tb_router_reg;
  import router_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  router_reg_if bus ();

  router_reg dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] dout;
    logic              pd;
    logic              lpv;
    logic              err;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              cur;
  logic [DATA_W-1:0] pkt_bytes[$];
  int                n_tests = 0;
  int                n_fail  = 0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout",          bus.dout,                  e.dout);
      chk("parity_done",   {7'd0, bus.parity_done},   {7'd0, e.pd});
      chk("low_pkt_valid", {7'd0, bus.low_pkt_valid}, {7'd0, e.lpv});
      chk("err",           {7'd0, bus.err},           {7'd0, e.err});
    end
  end

  task automatic idle();
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
    bus.fifo_full   = 1'($urandom);
    bus.pkt_valid   = 1'($urandom);
    bus.data_in     = 8'($urandom);
  endtask

  task automatic step();
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      resetn = 1'b0;
      {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
       bus.full_state, bus.rst_int_reg, bus.fifo_full, bus.pkt_valid} = 8'($urandom);
      bus.data_in = 8'($urandom);
      cur = '0;
      step();
    end
    resetn = 1'b1;
    idle();
  endtask

  // pkt_bytes = header, payload..., parity byte. Expected err comes from the packet contents.
  task automatic send_pkt(input int full_at, input int full_cyc, input int rst_at, input bit pre_decode);
    int          n;
    logic [7:0]  x;
    logic        bad;
    bit          last;
    n = pkt_bytes.size();
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x ^= pkt_bytes[i];
    bad = (x != pkt_bytes[n-1]);

    if (pre_decode) begin
      idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b0;
      cur.pd = 1'b0;
      step();
    end
    idle(); bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = pkt_bytes[0];
    cur.pd = 1'b0; cur.err = 1'b0;
    step();
    idle(); bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = pkt_bytes[1];
    cur.dout = pkt_bytes[0];
    step();

    for (int k = 1; k < n; k++) begin
      last = (k == n - 1);
      if (k == rst_at) begin
        do_reset($urandom_range(1, 2));
        return;
      end
      idle(); bus.ld_state = 1'b1; bus.pkt_valid = !last; bus.data_in = pkt_bytes[k];
      bus.fifo_full = (k == full_at);
      if (last) cur.lpv = 1'b1;
      if (k != full_at) begin
        cur.dout = pkt_bytes[k];
        if (last) cur.pd = 1'b1;
        step();
      end else begin
        step();
        for (int c = 0; c < full_cyc; c++) begin
          idle(); bus.full_state = 1'b1; bus.fifo_full = (c < full_cyc - 1);
          bus.pkt_valid = !last; bus.data_in = pkt_bytes[k];
          step();
        end
        idle(); bus.laf_state = 1'b1; bus.fifo_full = 1'b0;
        bus.pkt_valid = !last; bus.data_in = pkt_bytes[k];
        cur.dout = pkt_bytes[k];
        if (last) cur.pd = 1'b1;
        step();
      end
    end

    idle(); bus.rst_int_reg = 1'b1;
    cur.lpv = 1'b0; cur.err = bad;
    step();
    for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
      idle();
      step();
    end
  endtask

  task automatic build_random();
    int         len;
    logic [1:0] addr;
    logic [7:0] x;
    len  = $urandom_range(1, 12);
    addr = 2'($urandom_range(0, 2));
    pkt_bytes = {};
    pkt_bytes.push_back({6'(len), addr});
    for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
    x = 8'h00;
    foreach (pkt_bytes[i]) x ^= pkt_bytes[i];
    if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
    pkt_bytes.push_back(x);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    cur = '0;
    idle();
    do_reset(2);

    // Header 0D and payload A1 B2 C3 fold to DD
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(-1, 0, -1, 1'b0);
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hD0};
    send_pkt(-1, 0, -1, 1'b0);
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(2, 2, -1, 1'b1);
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hD1};
    send_pkt(4, 1, -1, 1'b0);
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(4, 3, -1, 1'b1);
    pkt_bytes = {8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(-1, 0, 2, 1'b0);
    pkt_bytes = {8'h06, 8'h5A, 8'h5C};
    send_pkt(-1, 0, -1, 1'b0);

    for (int p = 0; p < 40; p++) begin
      build_random();
      n = pkt_bytes.size();
      send_pkt(($urandom_range(0, 9) < 3) ? int'($urandom_range(1, n - 1)) : -1,
               $urandom_range(1, 3),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, n - 1)) : -1,
               1'($urandom));
    end
    do_reset(2);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
